booth_result_collector: RTL

Downstream stage of the Booth multiplier. The multiplier presents its 2·WIDTH-bit product as two WIDTH-bit halves on one bus, over two consecutive done cycles. This block reassembles each product and buffers it in a small FIFO drained by a valid/ready consumer. It also tracks the multiplication in flight and drives a `can_start` permission, so upstream issues a new start only when there is buffer space for its result.

---
 rtl/booth_result_collector.sv | 122 ++++++++++++
 1 files changed

// File: rtl/booth_result_collector.sv
// Reassembles two-half Booth products into {hi, lo} words and buffers them in a FIFO.
// Tracks the multiplication in flight so upstream only starts when a result slot exists.
module booth_result_collector #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mul_start,
   input  logic                       mul_done,
   input  logic                       mul_sel_out,
   input  logic [WIDTH-1:0]           mul_data,
   input  logic                       clr_err,
   output logic                       can_start,
   output logic                       prod_valid,
   input  logic                       prod_ready,
   output logic [2*WIDTH-1:0]         prod_data,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       overflow,
   output logic                       seq_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

   localparam logic [0:0] StIdle   = 1'b0;
   localparam logic [0:0] StWaitLo = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic               in_flight_q, in_flight_d;
   logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [PW:0]        count_q, count_d;
   logic               ovf_q, ovf_d, seq_q, seq_d;
   logic [2*WIDTH-1:0] mem_q [DEPTH];

   logic push_req, abort, seq_ev, full, pop, push, drop;

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      push_req = 1'b0;
      abort    = 1'b0;
      seq_ev   = 1'b0;
      case (state_q)
         StIdle: begin
            if (mul_done) begin
               if (mul_sel_out) begin
                  hi_d    = mul_data;
                  state_d = StWaitLo;
               end else begin
                  seq_ev = 1'b1;
               end
            end
         end
         default: begin
            // Only a back-to-back low half completes the product; any gap aborts it.
            if (!mul_done) begin
               seq_ev  = 1'b1;
               abort   = 1'b1;
               state_d = StIdle;
            end else if (mul_sel_out) begin
               seq_ev = 1'b1;
               hi_d   = mul_data;
            end else begin
               push_req = 1'b1;
               state_d  = StIdle;
            end
         end
      endcase
   end

   always_comb begin
      full        = (count_q == FullCount);
      pop         = prod_valid & prod_ready;
      // A full FIFO still accepts the push when the head leaves in the same cycle.
      push        = push_req & (~full | pop);
      drop        = push_req & full & ~pop;
      in_flight_d = mul_start | (in_flight_q & ~(push | drop | abort));
      count_d     = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      ovf_d       = drop | (ovf_q & ~clr_err);
      seq_d       = seq_ev | (seq_q & ~clr_err);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         hi_q        <= '0;
         in_flight_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         seq_q       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         in_flight_q <= in_flight_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         seq_q       <= seq_d;
         if (push) begin
            mem_q[wr_ptr_q] <= {hi_q, mul_data};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   assign prod_valid = (count_q != '0);
   assign prod_data  = mem_q[rd_ptr_q];
   assign fifo_count = count_q;
   assign can_start  = ~in_flight_q & (count_q < FullCount);
   assign overflow   = ovf_q;
   assign seq_err    = seq_q;

endmodule
